// File: rtl/mixer_ctrl.sv
// Mixer control block: per-channel shadow configuration on the CPU native bus and a
// timed sequencer that applies one channel's configuration to the analog pins.
module mixer_ctrl #(
    parameter int N_CH       = 4,
    parameter int BUFF_W     = 2,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 3,
    parameter int SETTLE_W   = 16,
    parameter int SETTLE_RST = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid,
    input  logic [ADDR_W-1:0]        address,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     wstrb,
    output logic [DATA_W-1:0]        rdata,
    output logic                     ready,
    output logic [N_CH-1:0]          pd,
    output logic [N_CH-1:0]          ota,
    output logic [N_CH*BUFF_W-1:0]   buff,
    output logic                     busy
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CFG_W = BUFF_W + 2;

    localparam logic [ADDR_W-1:0] A_CH_SEL = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CFG    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_SETTLE = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_APPLY  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(4);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S1,
        ST_W1,
        ST_S2,
        ST_W2,
        ST_S3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [CH_W-1:0]        r_ch_sel;
    logic [SETTLE_W-1:0]    r_settle;
    logic                   r_err;
    logic                   r_busy;
    logic                   r_ready;
    logic [DATA_W-1:0]      r_rdata;

    logic [CH_W-1:0]        r_lat_ch;
    logic [CFG_W-1:0]       r_lat_cfg;
    logic [SETTLE_W-1:0]    r_lat_settle;
    logic [SETTLE_W-1:0]    r_cnt;

    logic [CFG_W-1:0]       w_shadow [N_CH];
    logic [DATA_W-1:0]      w_rdata_mux;

    logic w_wr;
    logic w_rd;
    logic w_apply;
    logic w_accept;
    logic w_overrun;
    logic w_wr_pd;
    logic w_wr_ota;
    logic w_wr_buff;
    logic w_load_cnt;
    logic w_dec_cnt;

    assign w_wr      = valid & wstrb;
    assign w_rd      = valid & ~wstrb;
    assign w_apply   = w_wr && (address == A_APPLY);
    assign w_accept  = w_apply & ~r_busy;
    assign w_overrun = w_apply & r_busy;

    // Power-up enables bias before the OTA and buffer; power-down tears down in reverse.
    always_comb begin
        w_state_next = r_state;
        w_wr_pd      = 1'b0;
        w_wr_ota     = 1'b0;
        w_wr_buff    = 1'b0;
        w_load_cnt   = 1'b0;
        w_dec_cnt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = ST_S1;
            end
            ST_S1: begin
                if (r_lat_cfg[0]) w_wr_buff = 1'b1;
                else              w_wr_pd   = 1'b1;
                w_load_cnt   = 1'b1;
                w_state_next = (r_lat_settle == '0) ? ST_S2 : ST_W1;
            end
            ST_W1: begin
                w_dec_cnt = 1'b1;
                if (r_cnt <= SETTLE_W'(1)) w_state_next = ST_S2;
            end
            ST_S2: begin
                w_wr_ota     = 1'b1;
                w_load_cnt   = 1'b1;
                w_state_next = (r_lat_settle == '0) ? ST_S3 : ST_W2;
            end
            ST_W2: begin
                w_dec_cnt = 1'b1;
                if (r_cnt <= SETTLE_W'(1)) w_state_next = ST_S3;
            end
            ST_S3: begin
                if (r_lat_cfg[0]) w_wr_pd   = 1'b1;
                else              w_wr_buff = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_lat_ch     <= '0;
            r_lat_cfg    <= '0;
            r_lat_settle <= '0;
            r_cnt        <= '0;
        end else begin
            r_state <= w_state_next;
            // busy lags the state by one edge so the S3 write is still covered.
            r_busy  <= w_accept || (r_state != ST_IDLE);
            if (w_accept) begin
                r_lat_ch     <= r_ch_sel;
                r_lat_cfg    <= w_shadow[r_ch_sel];
                r_lat_settle <= r_settle;
            end
            if (w_load_cnt)     r_cnt <= r_lat_settle;
            else if (w_dec_cnt) r_cnt <= r_cnt - SETTLE_W'(1);
        end
    end

    always_comb begin
        w_rdata_mux = '0;
        case (address)
            A_CH_SEL: w_rdata_mux = DATA_W'(r_ch_sel);
            A_CFG:    w_rdata_mux = DATA_W'(w_shadow[r_ch_sel]);
            A_SETTLE: w_rdata_mux = DATA_W'(r_settle);
            A_STATUS: w_rdata_mux = DATA_W'({r_err, r_busy});
            default:  w_rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch_sel <= '0;
            r_settle <= SETTLE_W'(SETTLE_RST);
            r_err    <= 1'b0;
            r_ready  <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_ready <= valid;
            r_rdata <= w_rd ? w_rdata_mux : '0;
            if (w_wr && (address == A_CH_SEL) && (wdata < DATA_W'(N_CH)))
                r_ch_sel <= wdata[CH_W-1:0];
            if (w_wr && (address == A_SETTLE))
                r_settle <= wdata[SETTLE_W-1:0];
            // A new overrun wins over the clear-on-read of the same cycle.
            if (w_overrun)
                r_err <= 1'b1;
            else if (w_rd && (address == A_STATUS))
                r_err <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic              r_sh;
            logic [CFG_W-1:0]  r_shadow;
            logic              r_pd;
            logic              r_ota;
            logic [BUFF_W-1:0] r_buff;
            logic              w_sel;
            logic              w_cfg_wr;

            assign w_sel    = (r_lat_ch == CH_W'(gi));
            assign w_cfg_wr = w_wr && (address == A_CFG) && (r_ch_sel == CH_W'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_shadow <= '0;
                    r_sh     <= 1'b0;
                    r_pd     <= 1'b0;
                    r_ota    <= 1'b0;
                    r_buff   <= '0;
                end else begin
                    if (w_cfg_wr) begin
                        r_shadow <= wdata[CFG_W-1:0];
                        r_sh     <= 1'b1;
                    end
                    if (w_sel && w_wr_pd)   r_pd   <= r_lat_cfg[0];
                    if (w_sel && w_wr_ota)  r_ota  <= r_lat_cfg[1];
                    if (w_sel && w_wr_buff) r_buff <= r_lat_cfg[2 +: BUFF_W];
                end
            end

            assign w_shadow[gi]                 = r_shadow;
            assign pd[gi]                       = r_pd;
            assign ota[gi]                      = r_ota;
            assign buff[gi*BUFF_W +: BUFF_W]    = r_buff;
        end
    endgenerate

    assign rdata = r_rdata;
    assign ready = r_ready;
    assign busy  = r_busy;

endmodule

// File: tb/tb_mixer_ctrl.sv
// Bench for mixer_ctrl: register-map vector table, timed corner sequences and
// random bus traffic checked cycle by cycle against an event-schedule model.
module tb_mixer_ctrl;
    localparam int N_CH   = 4;
    localparam int BUFF_W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  address = '0;
    logic [31:0] wdata = '0;
    logic        wstrb = 1'b0;
    logic [31:0] rdata;
    logic        ready;
    logic [3:0]  pd;
    logic [3:0]  ota;
    logic [7:0]  buff;
    logic        busy;

    mixer_ctrl #(
        .N_CH(N_CH), .BUFF_W(BUFF_W), .DATA_W(32), .ADDR_W(3),
        .SETTLE_W(16), .SETTLE_RST(16)
    ) dut (
        .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .ready(ready), .pd(pd), .ota(ota),
        .buff(buff), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: register file plus a schedule of future pin changes.
    typedef struct { int t; int ch; int kind; int val; } ev_t;
    ev_t evq[$];
    int  m_pd[N_CH], m_ota[N_CH], m_buff[N_CH], m_sh[N_CH];
    int  m_ch, m_settle, m_err, m_start, m_end;
    int  m_exp_rd;
    int  last_e0;
    bit  chk_en = 0;

    function automatic void model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_pd[c] = 0; m_ota[c] = 0; m_buff[c] = 0; m_sh[c] = 0;
        end
        m_ch = 0; m_settle = 16; m_err = 0; m_start = 0; m_end = -100;
        evq.delete();
    endfunction

    function automatic bit m_busy_after(int k);
        return (k >= m_start) && (k < m_end);
    endfunction

    logic [3:0] mon_pd, mon_ota;
    logic [7:0] mon_buff;
    int         mon_i;

    always @(negedge clk) begin
        if (chk_en) begin
            mon_i = 0;
            while (mon_i < evq.size()) begin
                if (evq[mon_i].t <= cyc) begin
                    case (evq[mon_i].kind)
                        0: m_pd[evq[mon_i].ch]   = evq[mon_i].val;
                        1: m_ota[evq[mon_i].ch]  = evq[mon_i].val;
                        default: m_buff[evq[mon_i].ch] = evq[mon_i].val;
                    endcase
                    evq.delete(mon_i);
                end else begin
                    mon_i++;
                end
            end
            for (int c = 0; c < N_CH; c++) begin
                mon_pd[c]  = m_pd[c][0];
                mon_ota[c] = m_ota[c][0];
                mon_buff[c*BUFF_W +: BUFF_W] = m_buff[c][1:0];
            end
            check("mon_pd", pd, mon_pd);
            check("mon_ota", ota, mon_ota);
            check("mon_buff", buff, mon_buff);
            check("mon_busy", busy, m_busy_after(cyc));
        end
    end

    // One bus access, starting and ending at a falling edge.
    task automatic do_op(input int a, input logic [31:0] d, input bit we, output logic [31:0] rd);
        int e0, s, c, cfg, p, o, b;
        e0 = cyc + 1;
        last_e0 = e0;
        valid = 1'b1; address = a[2:0]; wdata = d; wstrb = we;
        m_exp_rd = 0;
        if (!we) begin
            case (a)
                0: m_exp_rd = m_ch;
                1: m_exp_rd = m_sh[m_ch];
                2: m_exp_rd = m_settle;
                4: begin
                    m_exp_rd = (m_err << 1) | int'(m_busy_after(e0 - 1));
                    m_err = 0;
                end
                default: m_exp_rd = 0;
            endcase
        end else begin
            case (a)
                0: if (d < N_CH) m_ch = int'(d);
                1: m_sh[m_ch] = int'(d & 32'hF);
                2: m_settle = int'(d & 32'hFFFF);
                3: begin
                    if (e0 > m_end) begin
                        s = m_settle; c = m_ch; cfg = m_sh[c];
                        p = cfg & 1; o = (cfg >> 1) & 1; b = (cfg >> 2) & 3;
                        if (p == 0) begin
                            evq.push_back('{e0 + 1, c, 0, p});
                            evq.push_back('{e0 + s + 2, c, 1, o});
                            evq.push_back('{e0 + 2*s + 3, c, 2, b});
                        end else begin
                            evq.push_back('{e0 + 1, c, 2, b});
                            evq.push_back('{e0 + s + 2, c, 1, o});
                            evq.push_back('{e0 + 2*s + 3, c, 0, p});
                        end
                        m_start = e0;
                        m_end   = e0 + 2*s + 4;
                    end else begin
                        m_err = 1;
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        check("ready_hi", ready, 1'b1);
        rd = rdata;
        valid = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        logic [31:0] rd;
        do_op(a, d, 1'b1, rd);
    endtask

    task automatic rd_chk(input string name, input int a, input logic [31:0] exp);
        logic [31:0] rd;
        do_op(a, 32'h0, 1'b0, rd);
        check(name, rd, exp);
        check({name, "_model"}, rd, m_exp_rd);
    endtask

    task automatic idle();
        valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_lo", ready, 1'b0);
    endtask

    task automatic wait_until(input int k);
        while (cyc < k) idle();
    endtask

    typedef struct { int a; logic [31:0] d; bit we; logic [31:0] exp; } vec_t;
    vec_t tbl[17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int e, a, r;
        bit we;
        logic [31:0] d;

        tbl = '{
            '{2, 32'h0,  1'b0, 32'd16}, '{0, 32'h0,  1'b0, 32'd0},
            '{1, 32'h0,  1'b0, 32'd0},  '{4, 32'h0,  1'b0, 32'd0},
            '{0, 32'h2,  1'b1, 32'd0},  '{0, 32'h0,  1'b0, 32'd2},
            '{0, 32'h4,  1'b1, 32'd0},  '{0, 32'h0,  1'b0, 32'd2},
            '{1, 32'hE,  1'b1, 32'd0},  '{1, 32'h0,  1'b0, 32'hE},
            '{2, 32'h3,  1'b1, 32'd0},  '{2, 32'h0,  1'b0, 32'd3},
            '{5, 32'hFF, 1'b1, 32'd0},  '{3, 32'h0,  1'b0, 32'd0},
            '{5, 32'h0,  1'b0, 32'd0},  '{6, 32'h0,  1'b0, 32'd0},
            '{7, 32'h0,  1'b0, 32'd0}
        };

        repeat (2) @(negedge clk);
        check("rst_pd", pd, 4'h0);
        check("rst_ota", ota, 4'h0);
        check("rst_buff", buff, 8'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        model_reset();
        chk_en = 1;
        idle();

        // Register map, back-to-back accesses.
        for (int i = 0; i < 17; i++) begin
            do_op(tbl[i].a, tbl[i].d, tbl[i].we, rd);
            if (!tbl[i].we) check($sformatf("tbl%0d", i), rd, tbl[i].exp);
        end
        idle();

        // Power-up ch2, SETTLE=3, CFG=0xE (already programmed by the table).
        wr(3, 32'h0);
        e = last_e0;
        wait_until(e + 1);
        check("pu_pd2_e1", pd[2], 1'b0);
        wait_until(e + 4);
        check("pu_ota2_e4", ota[2], 1'b0);
        wait_until(e + 5);
        check("pu_ota2_e5", ota[2], 1'b1);
        wait_until(e + 8);
        check("pu_buff2_e8", buff[5:4], 2'd0);
        wait_until(e + 9);
        check("pu_buff2_e9", buff[5:4], 2'd3);
        check("pu_busy_e9", busy, 1'b1);
        wait_until(e + 10);
        check("pu_busy_e10", busy, 1'b0);
        check("pu_others_buff", buff & 8'hCF, 8'h0);
        check("pu_others_ota", ota, 4'b0100);

        // Power-down ch0, SETTLE=0, CFG=0x3.
        wr(0, 32'h0); wr(1, 32'h3); wr(2, 32'h0); wr(3, 32'h0);
        e = last_e0;
        rd_chk("pd_status_busy", 4, 32'h1);
        check("pd_buff0_e1", buff[1:0], 2'd0);
        wait_until(e + 2);
        check("pd_ota0_e2", ota[0], 1'b1);
        check("pd_pd0_e2", pd[0], 1'b0);
        wait_until(e + 3);
        check("pd_pd0_e3", pd[0], 1'b1);
        wait_until(e + 4);
        check("pd_busy_e4", busy, 1'b0);

        // Overrun at E2 of a SETTLE=5 sequence, plus shadow isolation.
        wr(0, 32'h2); wr(1, 32'h2); wr(2, 32'h5); wr(3, 32'h0);
        e = last_e0;
        wait_until(e + 1);
        wr(3, 32'h0);
        wr(1, 32'hD); wr(2, 32'h1);
        wait_until(e + 14);
        check("ov_buff2", buff[5:4], 2'd0);
        check("ov_ota2", ota[2], 1'b1);
        check("ov_pd2", pd[2], 1'b0);
        rd_chk("ov_status_err", 4, 32'h2);
        rd_chk("ov_status_clr", 4, 32'h0);
        wr(3, 32'h0);
        e = last_e0;
        wait_until(e + 1);
        check("iso_buff2_e1", buff[5:4], 2'd3);
        wait_until(e + 6);
        check("iso_pd2", pd[2], 1'b1);
        check("iso_ota2", ota[2], 1'b0);
        check("iso_busy", busy, 1'b0);

        // Reset in the middle of a sequence.
        wr(0, 32'h1); wr(1, 32'h2); wr(2, 32'h3); wr(3, 32'h0);
        e = last_e0;
        wait_until(e + 5);
        check("mid_ota1", ota[1], 1'b1);
        valid = 1'b1; address = 3'd3; wstrb = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        valid = 1'b0;
        model_reset();
        #1;
        check("mrst_pd", pd, 4'h0);
        check("mrst_ota", ota, 4'h0);
        check("mrst_buff", buff, 8'h0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_ready", ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        rd_chk("mrst_settle", 2, 32'd16);
        rd_chk("mrst_chsel", 0, 32'd0);
        idle();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                idle();
            end else begin
                a  = $urandom_range(0, 7);
                we = 1'($urandom_range(0, 1));
                if (r == 9) begin a = 3; we = 1'b1; end
                if (a == 0)      d = 32'($urandom_range(0, 5));
                else if (a == 2) d = 32'($urandom_range(0, 4));
                else             d = $urandom;
                do_op(a, d, we, rd);
                if (!we) check($sformatf("rand_rd_a%0d", a), rd, m_exp_rd);
            end
        end
        wait_until(cyc + 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mixer_ctrl.md
# mixer_ctrl

Parametrised, multi-channel control block for the receiver's analog mixers, attached to the CPU native bus. It holds per-channel shadow configuration (power-down, OTA enable, buffer setting) and applies a channel's configuration to its analog control pins through a timed sequencer. Each step is separated by a programmable settle interval, so bias and OTA circuits stabilise before downstream stages are enabled.

## Interface
- N_CH, 4: number of mixer channels (1..16)
- BUFF_W, 2: width of each channel's buffer-control field
- DATA_W, 32: CPU data width
- ADDR_W, 3: CPU address width
- SETTLE_W, 16: width of the settle counter
- SETTLE_RST, 16: reset value of the SETTLE register
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- valid  in  1  CPU request
- address  in  ADDR_W  register address
- wdata  in  DATA_W  write data
- wstrb  in  1  1 = write, 0 = read
- rdata  out  DATA_W  read data, valid while ready=1
- ready  out  1  request acknowledge
- pd  out  N_CH  per-channel power-down
- ota  out  N_CH  per-channel OTA enable
- buff  out  N_CH*BUFF_W  per-channel buffer control; channel i occupies [i*BUFF_W +: BUFF_W]
- busy  out  1  sequencer active

## Operation
- Register map (word address):
  - 0 CH_SEL: R/W, selected channel index. A write with a value ≥ N_CH is ignored.
  - 1 CFG: R/W shadow of the selected channel. Fields are bit0 pd, bit1 ota, bits[2 +: BUFF_W] buff.
  - 2 SETTLE: R/W, SETTLE_W bits.
  - 3 APPLY: write of any value starts the sequencer for the CH_SEL channel. Reads return 0.
  - 4 STATUS: RO. bit0 busy, bit1 sticky apply-overrun error. A read clears bit1.
  - 5..7: writes are ignored; reads return 0.
- Shadow writes never touch the pd/ota/buff outputs directly. Only the sequencer drives them.
- On APPLY, the sequencer latches the channel index, that channel's shadow fields and SETTLE. Later writes to shadows or SETTLE do not affect a sequence already in progress.
- Step order depends on the latched pd field:
  - pd=0 (power-up): S1 writes pd, S2 writes ota, S3 writes buff.
  - pd=1 (power-down): S1 writes buff, S2 writes ota, S3 writes pd.
- FSM states and transitions:
  - IDLE → S1 on an accepted APPLY.
  - S1 → W1 → S2 → W2 → S3 → IDLE.
  - Each Wx lasts exactly SETTLE cycles. With SETTLE=0, Wx is skipped.
- APPLY while busy=1 is dropped, sets STATUS bit1, and leaves the running sequence unaffected.
- Only the latched channel's outputs change. Other channels hold their values.

## Timing
- Reset values:
  - pd, ota, buff, busy, ready, rdata, CH_SEL, shadows: all 0.
  - SETTLE = SETTLE_RST.
  - FSM in IDLE, error bit 0.
- Bus handshake:
  - ready rises one cycle after every cycle in which valid=1 (reads and writes alike) and is low otherwise.
  - rdata is registered together with ready.
  - Back-to-back valid cycles give back-to-back ready cycles.
- APPLY timing, taking the clock edge that samples the APPLY write as E0:
  - busy=1 from E0.
  - S1 output changes at E1.
  - S2 output changes at E1+SETTLE+1.
  - S3 output changes at E1+2*(SETTLE+1).
  - busy returns to 0 at the following edge.
- Settle counter: loaded with the latched SETTLE in each Sx and decremented in Wx. Its full SETTLE_W range is usable, with no wrap.
- Asserting rst mid-sequence immediately forces all outputs to their reset values and the FSM to IDLE. No partial step completes.
- APPLY on the same edge that returns busy to 0 (S3 → IDLE) is treated as overrun and dropped.

## Test plan
- Reset: assert rst mid-sequence → pd=ota=buff=0, busy=0, ready=0 within the same cycle. SETTLE reads back 16 after reset.
- Power-up, ch2, SETTLE=3, CFG=0b1110 (pd=0, ota=1, buff=3):
  - APPLY at E0 → pd[2]=0 at E1, ota[2]=1 at E5, buff[5:4]=3 at E9.
  - busy falls at E10.
  - Other channels are unchanged.
- Power-down, ch0, SETTLE=0, CFG=0b0011:
  - buff[1:0]=0 at E1, ota[0]=1 at E2, pd[0]=1 at E3.
  - STATUS reads busy=1 during the sequence.
- Overrun: second APPLY at E2 of a SETTLE=5 sequence → first sequence completes unchanged. STATUS reads 0b10, then reads 0b00.
- Shadow isolation: write CFG and SETTLE during busy → the running sequence uses the values latched at APPLY. A subsequent APPLY uses the new values.
- Bus/map:
  - CH_SEL write of N_CH → readback keeps the old index.
  - Reads of addresses 3, 5, 6, 7 return 0.
  - ready pulses exactly one cycle after each valid for 4 back-to-back accesses.
